// File: rtl/serial_addsub_alu_if.sv
// serial_addsub_alu_if: ALU request/result bundle (start, op, a, b in; ready, done, s, of, eq, cary out)
interface serial_addsub_alu_if #(parameter int WIDTH = 32);
  logic start;
  logic op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic ready;
  logic done;
  logic [WIDTH-1:0] s;
  logic of;
  logic eq;
  logic cary;
  modport master (output start, op, a, b, input ready, done, s, of, eq, cary);
  modport slave (input start, op, a, b, output ready, done, s, of, eq, cary);
endinterface

// File: rtl/serial_addsub_alu.sv
// serial_addsub_alu: chunk-serial add/sub ALU, LSB chunk first; ports clk, rst (sync, active-high), bus (slave: start/op/a/b -> ready/done/s/of/eq/cary)
module serial_addsub_alu #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic clk,
  input logic rst,
  serial_addsub_alu_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  logic [0:0] state;
  logic [WIDTH-1:0] ra, rb, acc, res;
  logic [KW-1:0] k;
  logic carry, zacc, op_r, a_msb, b_msb, last, ovf;
  logic [CHUNK:0] csum;
  always_comb begin
    csum = {1'b0, ra[CHUNK-1:0]} + {1'b0, rb[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    res = WIDTH'({csum[CHUNK-1:0], acc} >> CHUNK);
    last = k == KW'(NCHUNK - 1);
    ovf = (op_r ? a_msb != b_msb : a_msb == b_msb) && res[WIDTH-1] != a_msb;
  end
  assign bus.ready = state == IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      acc <= '0;
      k <= '0;
      carry <= 1'b0;
      zacc <= 1'b0;
      op_r <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      bus.done <= 1'b0;
      bus.s <= '0;
      bus.of <= 1'b0;
      bus.eq <= 1'b0;
      bus.cary <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          ra <= bus.a;
          rb <= bus.op ? ~bus.b : bus.b;
          carry <= bus.op;
          op_r <= bus.op;
          a_msb <= bus.a[WIDTH-1];
          b_msb <= bus.b[WIDTH-1];
          k <= '0;
          zacc <= 1'b1;
          state <= RUN;
        end
      end else begin
        acc <= res;
        ra <= ra >> CHUNK;
        rb <= rb >> CHUNK;
        carry <= csum[CHUNK];
        zacc <= zacc && csum[CHUNK-1:0] == '0;
        k <= k + 1'b1;
        if (last) begin
          bus.s <= res;
          bus.of <= ovf;
          bus.eq <= zacc && csum[CHUNK-1:0] == '0;
          bus.cary <= csum[CHUNK];
          bus.done <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_addsub_alu.sv
// tb_serial_addsub_alu: table, corner-sequence and random checks of serial_addsub_alu at 32/8 and 16/16
module tb_serial_addsub_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  serial_addsub_alu_if #(.WIDTH(32)) b32();
  serial_addsub_alu_if #(.WIDTH(16)) b16();
  serial_addsub_alu #(.WIDTH(32), .CHUNK(8)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
  serial_addsub_alu #(.WIDTH(16), .CHUNK(16)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));
  int checks = 0;
  int failures = 0;
  typedef struct {
    bit op;
    logic [31:0] a, b, s;
    bit of, eq, cy;
  } vec_t;
  vec_t vt[7];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  function automatic void model(input bit w16, input bit op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] s, output bit of, output bit eq, output bit cy);
    int w;
    longint ua, ub, sa, sb, r, mask, mx, mn;
    w = w16 ? 16 : 32;
    ua = w16 ? longint'(a[15:0]) : longint'(a);
    ub = w16 ? longint'(b[15:0]) : longint'(b);
    sa = w16 ? longint'($signed(a[15:0])) : longint'($signed(a));
    sb = w16 ? longint'($signed(b[15:0])) : longint'($signed(b));
    mask = (longint'(1) << w) - 1;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(longint'(1) << (w - 1));
    r = op ? sa - sb : sa + sb;
    of = r > mx || r < mn;
    s = 32'((op ? ua - ub : ua + ub) & mask);
    cy = op ? ua >= ub : ((ua + ub) >> w) != 0;
    eq = s == 0;
  endfunction
  task automatic drive(input bit w16, input bit start, input bit op, input logic [31:0] a, input logic [31:0] b);
    if (w16) begin
      b16.start = start; b16.op = op; b16.a = a[15:0]; b16.b = b[15:0];
    end else begin
      b32.start = start; b32.op = op; b32.a = a; b32.b = b;
    end
  endtask
  task automatic run_op(input bit w16, input bit op, input logic [31:0] a, input logic [31:0] b, input bit noisy,
                        output int lat, output bit rdy_bad);
    drive(w16, 1'b1, op, a, b);
    tick();
    lat = 0;
    rdy_bad = 0;
    while (lat < 20) begin
      drive(w16, noisy, 1'($urandom), $urandom, $urandom);
      if (w16 ? b16.ready : b32.ready) rdy_bad = 1;
      tick();
      lat++;
      if (w16 ? b16.done : b32.done) break;
    end
    if (w16) b16.start = 1'b0; else b32.start = 1'b0;
  endtask
  task automatic check_model(input string name, input bit w16, input bit op, input logic [31:0] a, input logic [31:0] b, input int lat);
    logic [31:0] es;
    bit eo, ee, ec;
    model(w16, op, a, b, es, eo, ee, ec);
    check({name, ".s"}, w16 ? {16'h0, b16.s} : b32.s, es);
    check({name, ".flags"}, w16 ? {b16.of, b16.eq, b16.cary} : {b32.of, b32.eq, b32.cary}, {eo, ee, ec});
    check({name, ".lat"}, lat, w16 ? 1 : 4);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int lat;
    bit rb;
    bit seen;
    vt[0] = '{1'b1, 32'd5000, 32'd5000, 32'h0, 1'b0, 1'b1, 1'b1};
    vt[1] = '{1'b1, 32'h0, 32'hAAAAAAAA, 32'h55555556, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 32'd15000, 32'hFFFFEC78, 32'h00004E20, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b0, 32'd2000000000, 32'd2000000000, 32'hEE6B2800, 1'b1, 1'b0, 1'b0};
    vt[4] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1};
    vt[5] = '{1'b1, 32'h88CA6C00, 32'h88CA6C00, 32'h0, 1'b0, 1'b1, 1'b1};
    vt[6] = '{1'b0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1, 1'b0, 1'b0};
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 0, 0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("reset32", {b32.ready, b32.done, b32.of, b32.eq, b32.cary, b32.s}, {5'b10000, 32'h0});
    check("reset16", {b16.ready, b16.done, b16.of, b16.eq, b16.cary, b16.s}, {5'b10000, 16'h0});
    for (int i = 0; i < 7; i++) begin
      run_op(1'b0, vt[i].op, vt[i].a, vt[i].b, 1'b0, lat, rb);
      check($sformatf("vec%0d.s", i), b32.s, vt[i].s);
      check($sformatf("vec%0d.flags", i), {b32.of, b32.eq, b32.cary}, {vt[i].of, vt[i].eq, vt[i].cy});
      check($sformatf("vec%0d.lat", i), lat, 4);
      check($sformatf("vec%0d.busy_ready", i), rb, 0);
      check($sformatf("vec%0d.done_ready", i), b32.ready, 1);
      tick();
      check($sformatf("vec%0d.hold", i), {b32.done, b32.s}, {1'b0, vt[i].s});
    end
    run_op(1'b0, vt[5].op, vt[5].a, vt[5].b, 1'b0, lat, rb);
    check("b2b.first.s", {b32.s, b32.eq, b32.cary}, {32'h0, 2'b11});
    run_op(1'b0, vt[6].op, vt[6].a, vt[6].b, 1'b0, lat, rb);
    check("b2b.second.s", {b32.s, b32.of}, {32'h80000000, 1'b1});
    check("b2b.second.lat", lat, 4);
    run_op(1'b0, 1'b1, 32'd100, 32'd30, 1'b1, lat, rb);
    check_model("ignore_start", 1'b0, 1'b1, 32'd100, 32'd30, lat);
    tick();
    check("ignore_start.idle", {b32.ready, b32.done}, 2'b10);
    drive(1'b0, 1'b1, 1'b0, 32'd1234, 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_run.outs", {b32.ready, b32.done, b32.of, b32.eq, b32.cary, b32.s}, {5'b10000, 32'h0});
    seen = 0;
    repeat (6) begin
      tick();
      if (b32.done) seen = 1;
    end
    check("rst_run.no_done", seen, 0);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'd9, 32'd9);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    seen = 0;
    repeat (5) begin
      if (!b32.ready || b32.done) seen = 1;
      tick();
    end
    check("rst_start.ignored", {seen, b32.s}, {1'b0, 32'h0});
    run_op(1'b1, 1'b1, 32'h8000, 32'h1, 1'b0, lat, rb);
    check("w16.sub.s", b16.s, 16'h7FFF);
    check("w16.sub.flags", {b16.of, b16.cary, b16.eq}, 3'b110);
    check("w16.sub.lat", lat, 1);
    for (int i = 0; i < 200; i++) begin
      bit w16, op;
      logic [31:0] a, b;
      w16 = i[0];
      op = 1'($urandom);
      a = $urandom;
      b = (i % 7 == 0) ? a : $urandom;
      run_op(w16, op, a, b, 1'($urandom), lat, rb);
      check_model($sformatf("rand%0d", i), w16, op, a, b, lat);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
